// File: rtl/oliver_core.sv
// oliver_core: three-word fetch/decode/execute core driving a single-outstanding memory master port.
// Build option: define OLIVER_CORE_MUL_EN to give opcode 14 (MUL) meaning; otherwise it faults.
module oliver_core #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 22,
    parameter int NUM_REGS  = 8,
    parameter int CODE_BASE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdvalid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              fault
);

    // Handshake: mem_rd/mem_wr stay high with stable mem_addr/mem_wdata until a cycle with
    // mem_waitrequest=0; only one read may be outstanding, and mem_rdvalid counts only while pend_q=1.

    localparam int                IDX_W = $clog2(NUM_REGS);
    localparam logic [DATA_W-1:0] BASE  = DATA_W'(CODE_BASE);
    localparam logic [DATA_W-1:0] NREG  = DATA_W'(NUM_REGS);

    typedef enum logic [3:0] {
        S_FETCH_OP, S_WAIT_OP, S_FETCH_A, S_WAIT_A, S_FETCH_B, S_WAIT_B,
        S_EXEC, S_MEM_LD, S_MEM_ST, S_HALT, S_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic              pend_q, pend_d;
    logic [7:0]        opc_q, opc_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              req_rd, req_wr, bad;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic [DATA_W-1:0] ip, ip_plus3, r1, r2, acc;
    logic [ADDR_W-1:0] ip_a;
    logic [IDX_W-1:0]  idx1, idx2;
    logic              ok1, ok2, rd_ok;

    assign ip       = regs_q[0];
    assign ip_plus3 = ip + DATA_W'(3);
    assign ip_a     = ip[ADDR_W-1:0];
    assign acc      = regs_q[1];
    assign idx1     = op1_q[IDX_W-1:0];
    assign idx2     = op2_q[IDX_W-1:0];
    assign r1       = regs_q[idx1];
    assign r2       = regs_q[idx2];
    assign ok1      = op1_q < NREG;
    assign ok2      = op2_q < NREG;
    assign rd_ok    = pend_q && mem_rdvalid;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        opc_d       = opc_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        regs_d      = regs_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        req_rd      = 1'b0;
        req_wr      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        bad         = 1'b0;

        case (state_q)
            S_FETCH_OP, S_FETCH_A, S_FETCH_B: begin
                req_rd   = 1'b1;
                req_addr = (state_q == S_FETCH_OP) ? ip_a :
                           (state_q == S_FETCH_A)  ? ip_a + ADDR_W'(1) : ip_a + ADDR_W'(2);
                if (!mem_waitrequest) begin
                    pend_d  = 1'b1;
                    state_d = (state_q == S_FETCH_OP) ? S_WAIT_OP :
                              (state_q == S_FETCH_A)  ? S_WAIT_A  : S_WAIT_B;
                end
            end
            S_WAIT_OP: if (rd_ok) begin opc_d = mem_rdata[7:0]; pend_d = 1'b0; state_d = S_FETCH_A; end
            S_WAIT_A:  if (rd_ok) begin op1_d = mem_rdata;      pend_d = 1'b0; state_d = S_FETCH_B; end
            S_WAIT_B:  if (rd_ok) begin op2_d = mem_rdata;      pend_d = 1'b0; state_d = S_EXEC;    end
            S_EXEC: begin
                // IP advance is written first so a later write to reg0 overrides it.
                state_d   = S_FETCH_OP;
                regs_d[0] = ip_plus3;
                case (opc_q)
                    8'd0: ;
                    8'd1: begin bad = !ok2; regs_d[0] = ip; state_d = S_MEM_LD; end
                    8'd2: begin bad = !ok1; regs_d[0] = ip; state_d = S_MEM_ST; end
                    8'd3: begin bad = !(ok1 && ok2); regs_d[1] = r1 + r2; end
                    8'd4: begin bad = !(ok1 && ok2); regs_d[1] = r1 - r2; end
                    8'd5: begin bad = !ok1; out_data_d = r1; out_valid_d = 1'b1; end
                    8'd6: begin bad = !ok1; regs_d[idx1] = in_data; end
                    8'd7: begin bad = !(ok1 && ok2); regs_d[idx2] = r1; end
                    8'd8: begin
                        bad       = !(ok1 && ok2);
                        regs_d[1] = (r1 < r2) ? DATA_W'(0) : (r1 == r2) ? DATA_W'(1) : DATA_W'(2);
                    end
                    8'd9:  if (acc == DATA_W'(0)) regs_d[0] = BASE + op1_q;
                    8'd10: if (acc == DATA_W'(1)) regs_d[0] = BASE + op1_q;
                    8'd11: if (acc == DATA_W'(2)) regs_d[0] = BASE + op1_q;
                    8'd12: begin
                        for (int i = 1; i < NUM_REGS; i++) regs_d[i] = '0;
                        regs_d[0] = BASE;
                    end
                    8'd13: begin regs_d[0] = ip; state_d = S_HALT; end
`ifdef OLIVER_CORE_MUL_EN
                    8'd14: begin bad = !(ok1 && ok2); regs_d[1] = r1 * r2; end
`endif
                    default: bad = 1'b1;
                endcase
                if (bad) begin
                    regs_d      = regs_q;
                    out_data_d  = out_data_q;
                    out_valid_d = 1'b0;
                    state_d     = S_FAULT;
                end
            end
            S_MEM_LD: begin
                if (!pend_q) begin
                    req_rd   = 1'b1;
                    req_addr = op1_q[ADDR_W-1:0];
                    if (!mem_waitrequest) pend_d = 1'b1;
                end else if (mem_rdvalid) begin
                    pend_d       = 1'b0;
                    regs_d[0]    = ip_plus3;
                    regs_d[idx2] = mem_rdata;
                    state_d      = S_FETCH_OP;
                end
            end
            S_MEM_ST: begin
                req_wr    = 1'b1;
                req_addr  = op2_q[ADDR_W-1:0];
                req_wdata = r1;
                if (!mem_waitrequest) begin
                    regs_d[0] = ip_plus3;
                    state_d   = S_FETCH_OP;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FETCH_OP;
            pend_q      <= 1'b0;
            opc_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            regs_q[0]   <= BASE;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            opc_q       <= opc_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            regs_q      <= regs_d;
        end
    end

    // Requests are masked by reset so they drop the instant reset_n falls.
    assign mem_rd    = req_rd & reset_n;
    assign mem_wr    = req_wr & reset_n;
    assign mem_addr  = (mem_rd | mem_wr) ? req_addr : '0;
    assign mem_wdata = mem_wr ? req_wdata : '0;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == S_HALT) || (state_q == S_FAULT);
    assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_oliver_core.sv
// Directed bench for oliver_core: small programs in a modelled 0-wait memory, checked with
// immediate assertions against hand-computed results.
module tb_oliver_core;

  logic        clk;
  logic        reset_n;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_waitrequest;
  logic [31:0] mem_rdata;
  logic        mem_rdvalid;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        halted;
  logic        fault;

  oliver_core dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_wdata       (mem_wdata),
    .mem_waitrequest (mem_waitrequest),
    .mem_rdata       (mem_rdata),
    .mem_rdvalid     (mem_rdvalid),
    .in_data         (in_data),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .halted          (halted),
    .fault           (fault)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory (owned by the stimulus) and store log (owned by the memory model)
  logic [31:0] mem    [0:511];
  logic [31:0] st_mem [0:511];

  int          stall_total;
  logic [21:0] stall_addr;
  int          stall_used;
  int          stall_ok;
  logic        stall_armed;
  logic        m_pend;
  logic [8:0]  m_addr;
  int          stale_req;
  int          stale_done;
  logic [31:0] stale_data;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  int          ov_cnt;
  logic [31:0] ov_data;

  localparam int JOP   [5] = '{9, 9, 10, 11, 11};
  localparam int BV    [5] = '{3, 5, 5, 7, 3};
  localparam int CV    [5] = '{5, 5, 5, 5, 5};
  localparam int EXPIP [5] = '{'h30, 12, 'h30, 'h30, 12};

  // Memory model: decisions made on the falling edge, read data one cycle after acceptance.
  always @(negedge clk) begin
    mem_rdvalid     = 1'b0;
    mem_rdata       = '0;
    mem_waitrequest = 1'b0;
    if (!reset_n) begin
      m_pend      = 1'b0;
      stall_used  = 0;
      stall_ok    = 0;
      stall_armed = 1'b0;
      for (int i = 0; i < 512; i++) st_mem[i] = '0;
    end else begin
      if (stale_req != stale_done) begin
        stale_done  = stale_req;
        mem_rdvalid = 1'b1;
        mem_rdata   = stale_data;
      end else if (m_pend) begin
        mem_rdvalid = 1'b1;
        mem_rdata   = mem[m_addr];
        m_pend      = 1'b0;
      end
      if (stall_used < stall_total && (stall_armed || (mem_rd && mem_addr == stall_addr))) begin
        stall_armed     = 1'b1;
        mem_waitrequest = 1'b1;
        stall_used++;
        if (mem_rd === 1'b1 && mem_wr === 1'b0 && mem_addr === stall_addr) stall_ok++;
      end else begin
        stall_armed = 1'b0;
      end
      if (!mem_waitrequest) begin
        if (mem_rd) begin
          m_pend = 1'b1;
          m_addr = mem_addr[8:0];
        end else if (mem_wr) begin
          st_mem[mem_addr[8:0]] = mem_wdata;
        end
      end
    end
  end

  // Driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = '0;
  endtask

  task automatic ins(input int a, input logic [31:0] op, input logic [31:0] x, input logic [31:0] y);
    mem[a]     = op;
    mem[a + 1] = x;
    mem[a + 2] = y;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic run(input int budget);
    cyc    = 0;
    ov_cnt = 0;
    while (halted !== 1'b1 && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid === 1'b1) begin
        ov_cnt++;
        ov_data = out_data;
      end
    end
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    ov_data     = '0;
    stall_total = 0;
    stall_addr  = '0;
    stale_req   = 0;
    stale_data  = '0;
    in_data     = '0;
    reset_n     = 1'b0;
    clear_mem();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd",     {63'd0, mem_rd}, 64'd0);
    check("rst_wr",     {63'd0, mem_wr}, 64'd0);
    check("rst_addr",   64'(mem_addr), 64'd0);
    check("rst_out",    {31'd0, out_data, out_valid}, 64'd0);
    check("rst_status", {62'd0, halted, fault}, 64'd0);
    check("rst_ip",     64'(dut.regs_q[0]), 64'd0);

    // NOP, NOP, HALT
    ins(0, 0, 0, 0); ins(3, 0, 0, 0); ins(6, 13, 0, 0);
    do_reset();
    #1 check("first_fetch", {41'd0, mem_rd, mem_addr}, {41'd0, 1'b1, 22'd0});
    run(100);
    check("nop_cycles", 64'(cyc), 64'd21);
    check("nop_status", {62'd0, halted, fault}, {62'd0, 1'b1, 1'b0});
    check("nop_ip",     64'(dut.regs_q[0]), 64'd6);

    // LOAD 0x100 -> B, STORE B -> 0x104, then again with a 5-cycle stall on the load
    for (int s = 0; s < 2; s++) begin
      clear_mem();
      ins(0, 1, 'h100, 2); ins(3, 2, 2, 'h104); ins(6, 13, 0, 0);
      mem['h100]  = 32'hDEAD_BEEF;
      stall_addr  = 22'h100;
      stall_total = (s == 0) ? 0 : 5;
      do_reset();
      run(200);
      check($sformatf("ldst%0d_mem", s),    64'(st_mem['h104]), 64'hDEAD_BEEF);
      check($sformatf("ldst%0d_cycles", s), 64'(cyc), (s == 0) ? 64'd24 : 64'd29);
      check($sformatf("ldst%0d_stable", s), 64'(stall_ok), (s == 0) ? 64'd0 : 64'd5);
    end
    stall_total = 0;

    // ADD wraps, OUT pulses once
    clear_mem();
    ins(0, 1, 'h100, 2); ins(3, 1, 'h101, 3); ins(6, 3, 2, 3); ins(9, 5, 1, 0); ins(12, 13, 0, 0);
    mem['h100] = 32'hFFFF_FFFF;
    mem['h101] = 32'd2;
    do_reset();
    run(200);
    check("add_out",    64'(ov_data), 64'd1);
    check("add_pulses", 64'(ov_cnt), 64'd1);
    check("add_hold",   64'(out_data), 64'd1);
    check("add_cycles", 64'(cyc), 64'd39);

    // CMP followed by conditional jumps
    for (int k = 0; k < 5; k++) begin
      clear_mem();
      ins(0, 1, 'h100, 2); ins(3, 1, 'h101, 3); ins(6, 8, 2, 3);
      ins(9, JOP[k], 'h30, 0); ins(12, 13, 0, 0); ins('h30, 13, 0, 0);
      mem['h100] = BV[k];
      mem['h101] = CV[k];
      do_reset();
      run(200);
      check($sformatf("jmp%0d_ip", k), 64'(dut.regs_q[0]), 64'(EXPIP[k]));
    end

    // IN, SUB, OUT, then LOAD into reg0 redirects IP
    clear_mem();
    ins(0, 6, 2, 0); ins(3, 1, 'h101, 3); ins(6, 4, 2, 3); ins(9, 5, 1, 0);
    ins(12, 1, 'h102, 0); ins('h40, 13, 0, 0);
    mem['h101] = 32'd3;
    mem['h102] = 32'h40;
    in_data    = 32'd10;
    do_reset();
    run(200);
    check("sub_out",   64'(ov_data), 64'd7);
    check("ld_ip",     64'(dut.regs_q[0]), 64'h40);
    check("sub_fault", {63'd0, fault}, 64'd0);
    in_data = '0;

    // MOV with destination index NUM_REGS faults with no side effects
    clear_mem();
    ins(0, 1, 'h100, 2); ins(3, 7, 2, 8); ins(6, 13, 0, 0);
    mem['h100] = 32'h55;
    do_reset();
    run(200);
    check("mov_status", {62'd0, halted, fault}, {62'd0, 1'b1, 1'b1});
    check("mov_b",      64'(dut.regs_q[2]), 64'h55);
    check("mov_a",      64'(dut.regs_q[1]), 64'd0);
    check("mov_ip",     64'(dut.regs_q[0]), 64'd3);

    // Opcode 14 with 7*6
    clear_mem();
    ins(0, 1, 'h100, 2); ins(3, 1, 'h101, 3); ins(6, 14, 2, 3); ins(9, 5, 1, 0); ins(12, 13, 0, 0);
    mem['h100] = 32'd7;
    mem['h101] = 32'd6;
    do_reset();
    run(200);
`ifdef OLIVER_CORE_MUL_EN
    check("mul_out",   64'(ov_data), 64'd42);
    check("mul_fault", {63'd0, fault}, 64'd0);
`else
    check("mul_fault",  {62'd0, halted, fault}, {62'd0, 1'b1, 1'b1});
    check("mul_no_out", 64'(ov_cnt), 64'd0);
    check("mul_ip",     64'(dut.regs_q[0]), 64'd6);
`endif

    // Reset while the opcode read is outstanding, stale read data after release
    clear_mem();
    ins(0, 0, 0, 0); ins(3, 0, 0, 0); ins(6, 13, 0, 0);
    do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("mid_rst_rd", {62'd0, mem_rd, mem_wr}, 64'd0);
    stall_addr  = 22'd0;
    stall_total = 3;
    stale_data  = 32'hFF;
    stale_req++;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run(200);
    check("stale_status", {62'd0, halted, fault}, {62'd0, 1'b1, 1'b0});
    check("stale_cycles", 64'(cyc), 64'd24);
    check("stale_ip",     64'(dut.regs_q[0]), 64'd6);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
